spi_host_ctrl: RTL and testbench

SPI_HOST_CTRL -- requirements
Module: spi_host_ctrl

---
 rtl/spi_host_pkg.sv | 22 ++
 rtl/spi_host_clkgen.sv | 49 ++++
 rtl/spi_host_ctrl.sv | 173 +++++++++++++++++
 tb/tb_spi_host_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_host_pkg.sv
// Shared types and widths for the SPI host controller and its clock generator.
package spi_host_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DIV_W  = 8;
    localparam int unsigned BIT_W  = 3;

    typedef enum logic {
        CMD_XFER = 1'b0,
        CMD_IRST = 1'b1
    } cmd_type_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_IRST,
        ST_DONE
    } state_e;

endpackage

// File: rtl/spi_host_clkgen.sv
// Half-period divider: strobes the first cycle of each slot, the first high
// cycle and the last high cycle while enabled; idles at slot start otherwise.
module spi_host_clkgen
    import spi_host_pkg::*;
#(
    parameter int unsigned HALF_DIV = 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic en,
    output logic slot_start_c,
    output logic rise_c,
    output logic fall_c
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             phase_q, phase_d;

    always_comb begin
        div_d   = '0;
        phase_d = 1'b0;
        if (en) begin
            if (div_q == DIV_LAST) begin
                div_d   = '0;
                phase_d = ~phase_q;
            end else begin
                div_d   = div_q + DIV_W'(1);
                phase_d = phase_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            phase_q <= phase_d;
        end
    end

    assign slot_start_c = en & ~phase_q & (div_q == '0);
    assign rise_c       = en &  phase_q & (div_q == '0);
    assign fall_c       = en &  phase_q & (div_q == DIV_LAST);

endmodule

// File: rtl/spi_host_ctrl.sv
// SPI-style host controller: address+data byte transfers with read-back, and
// an internal-reset pulse train on iclk. Pin outputs are registered.
module spi_host_ctrl
    import spi_host_pkg::*;
#(
    parameter int unsigned HALF_DIV    = 1,
    parameter int unsigned IRST_PULSES = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_type,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              sclk,
    output logic              iclk,
    output logic              serial_in,
    input  logic              serial_out
);

    localparam int unsigned PCNT_W = (IRST_PULSES > 1) ? $clog2(IRST_PULSES) : 1;
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(IRST_PULSES - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                samp_q, samp_d;
    logic                last_q, last_d;
    logic                sclk_q, sclk_d;
    logic                iclk_q, iclk_d;
    logic                sin_q, sin_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                busy_q, busy_d;
    logic                cmd_ready_q, cmd_ready_d;

    logic xfer_act, pulse_act, cur_bit;
    logic slot_start_c, rise_c, fall_c;

    assign xfer_act  = (state_q == ST_ADDR) || (state_q == ST_DATA);
    assign pulse_act = xfer_act || (state_q == ST_IRST);
    assign cur_bit   = (state_q == ST_ADDR) ? addr_q[bit_q] : wdata_q[bit_q];

    spi_host_clkgen #(.HALF_DIV(HALF_DIV)) u_clkgen (
        .clk          (clk),
        .rstn         (rstn),
        .en           (pulse_act),
        .slot_start_c (slot_start_c),
        .rise_c       (rise_c),
        .fall_c       (fall_c)
    );

    // Sequencing advances at each slot end; pins follow one cycle behind.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        bit_d   = bit_q;
        pcnt_d  = pcnt_q;
        shift_d = shift_q;
        rdata_d = rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    bit_d   = '1;
                    pcnt_d  = '0;
                    state_d = (cmd_type_e'(cmd_type) == CMD_IRST) ? ST_IRST : ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (fall_c) begin
                    bit_d = bit_q - BIT_W'(1);
                    if (bit_q == '0) state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (fall_c) begin
                    bit_d = bit_q - BIT_W'(1);
                    if (bit_q == '0) state_d = ST_DONE;
                end
            end
            ST_IRST: begin
                if (fall_c) begin
                    pcnt_d = pcnt_q + PCNT_W'(1);
                    if (pcnt_q == PCNT_LAST) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Sample strobe is delayed one cycle to land on the pin's falling edge.
        samp_d = (state_q == ST_DATA) && fall_c;
        last_d = samp_d && (bit_q == '0);
        if (samp_q) begin
            shift_d = {shift_q[DATA_W-2:0], serial_out};
            if (last_q) rdata_d = shift_d;
        end

        sclk_d = sclk_q;
        if (!xfer_act)         sclk_d = 1'b0;
        else if (rise_c)       sclk_d = 1'b1;
        else if (slot_start_c) sclk_d = 1'b0;

        iclk_d = iclk_q;
        if (!pulse_act)        iclk_d = 1'b0;
        else if (rise_c)       iclk_d = 1'b1;
        else if (slot_start_c) iclk_d = 1'b0;

        sin_d = sin_q;
        if (!xfer_act)         sin_d = 1'b0;
        else if (slot_start_c) sin_d = cur_bit;

        rsp_valid_d = (state_q == ST_DONE);
        busy_d      = (state_d != ST_IDLE) || (state_q == ST_DONE);
        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            bit_q       <= '0;
            pcnt_q      <= '0;
            shift_q     <= '0;
            rdata_q     <= '0;
            samp_q      <= 1'b0;
            last_q      <= 1'b0;
            sclk_q      <= 1'b0;
            iclk_q      <= 1'b0;
            sin_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            bit_q       <= bit_d;
            pcnt_q      <= pcnt_d;
            shift_q     <= shift_d;
            rdata_q     <= rdata_d;
            samp_q      <= samp_d;
            last_q      <= last_d;
            sclk_q      <= sclk_d;
            iclk_q      <= iclk_d;
            sin_q       <= sin_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign busy      = busy_q;
    assign sclk      = sclk_q;
    assign iclk      = iclk_q;
    assign serial_in = sin_q;

endmodule

// File: tb/tb_spi_host_ctrl.sv
// Bench for spi_host_ctrl: command table through a scoreboard on a HALF_DIV=1
// instance, plus hand sequences for held cmd_valid, reset abort and HALF_DIV=3.
module tb_spi_host_ctrl;
    import spi_host_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn;
    logic       cmd_valid, cmd_ready, cmd_type, rsp_valid, busy, sclk, iclk, serial_in;
    logic       serial_out = 1'b0;
    logic [7:0] cmd_addr, cmd_wdata, rsp_rdata;

    logic       c3_cmd_valid, c3_cmd_ready, c3_cmd_type, c3_rsp_valid, c3_busy;
    logic       c3_sclk, c3_iclk, c3_serial_in;
    logic       c3_serial_out = 1'b0;
    logic [7:0] c3_cmd_addr, c3_cmd_wdata, c3_rsp_rdata;

    spi_host_ctrl #(.HALF_DIV(1), .IRST_PULSES(8)) u_dut (
        .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_type(cmd_type), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy), .sclk(sclk),
        .iclk(iclk), .serial_in(serial_in), .serial_out(serial_out)
    );

    spi_host_ctrl #(.HALF_DIV(3), .IRST_PULSES(8)) u_dut3 (
        .clk(clk), .rstn(rstn), .cmd_valid(c3_cmd_valid), .cmd_ready(c3_cmd_ready),
        .cmd_type(c3_cmd_type), .cmd_addr(c3_cmd_addr), .cmd_wdata(c3_cmd_wdata),
        .rsp_valid(c3_rsp_valid), .rsp_rdata(c3_rsp_rdata), .busy(c3_busy), .sclk(c3_sclk),
        .iclk(c3_iclk), .serial_in(c3_serial_in), .serial_out(c3_serial_out)
    );

    typedef struct {
        logic       typ;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] so;
        logic [7:0] rdata;
    } vec_t;

    typedef struct {
        logic       typ;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] so;
        logic [7:0] rdata;
        int         acc;
    } exp_t;

    vec_t  vecs[7];
    exp_t  sb_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Pin monitor and chip model for the HALF_DIV=1 instance.
    exp_t        mon_e;
    logic [7:0]  mon_so;
    logic [15:0] bits = '0;
    logic        sclk_p = 1'b0, iclk_p = 1'b0;
    int          nrise = 0, niclk = 0, irst_bad = 0, n_rsp = 0;

    always @(negedge clk) begin
        if (!rstn) begin
            nrise = 0; niclk = 0; irst_bad = 0; sclk_p = 1'b0; iclk_p = 1'b0;
        end else begin
            if (sclk && !sclk_p) begin
                mon_so = (sb_q.size() > 0) ? sb_q[0].so : 8'h00;
                if (nrise < 16) bits[15-nrise] = serial_in;
                if (nrise >= 8 && nrise < 16) serial_out = mon_so[15-nrise];
                else                          serial_out = 1'($urandom);
                nrise++;
            end
            if (iclk && !iclk_p) niclk++;
            if (sb_q.size() > 0 && sb_q[0].typ && (sclk || serial_in)) irst_bad++;
            if (rsp_valid) begin
                n_rsp++;
                if (sb_q.size() == 0) check("unexpected_rsp_valid", 1, 0);
                else begin
                    mon_e = sb_q.pop_front();
                    check("rsp_rdata", 32'(rsp_rdata), 32'(mon_e.rdata));
                    check("rsp_latency", cyc - mon_e.acc, mon_e.typ ? 17 : 33);
                    check("rsp_busy", 32'(busy), 1);
                    check("sclk_pulses", nrise, mon_e.typ ? 0 : 16);
                    check("iclk_pulses", niclk, mon_e.typ ? 8 : 16);
                    if (mon_e.typ) check("irst_lines_quiet", irst_bad, 0);
                    else           check("serial_in_bits", 32'(bits), 32'({mon_e.addr, mon_e.wdata}));
                end
                nrise = 0; niclk = 0; irst_bad = 0;
            end
            sclk_p = sclk;
            iclk_p = iclk;
        end
    end

    // Run-length monitor and chip model for the HALF_DIV=3 instance.
    logic [15:0] c3_bits = '0;
    logic [7:0]  c3_so = 8'h3C;
    logic        c3_p = 1'b0;
    int          c3_hi = 0, c3_lo = 0, c3_rises = 0, c3_bad = 0;

    always @(negedge clk) begin
        if (rstn) begin
            if (c3_iclk !== c3_sclk) c3_bad++;
            if (c3_sclk) begin
                if (!c3_p) begin
                    if (c3_rises > 0 && c3_lo != 3) c3_bad++;
                    if (c3_rises < 16) c3_bits[15-c3_rises] = c3_serial_in;
                    c3_serial_out = (c3_rises >= 8 && c3_rises < 16) ? c3_so[15-c3_rises] : 1'b0;
                    c3_rises++;
                    c3_hi = 0;
                end
                c3_hi++;
            end else begin
                if (c3_p) begin
                    if (c3_hi != 3) c3_bad++;
                    c3_lo = 0;
                end
                c3_lo++;
            end
            c3_p = c3_sclk;
        end
    end

    task automatic send(input logic typ, input logic [7:0] a, input logic [7:0] w,
                        input logic [7:0] so, input logic [7:0] er);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) begin
            check("cmd_ready_timeout", 0, 1);
            return;
        end
        cmd_valid = 1'b1; cmd_type = typ; cmd_addr = a; cmd_wdata = w;
        sb_q.push_back('{typ: typ, addr: a, wdata: w, so: so, rdata: er, acc: cyc + 1});
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 1000) begin @(negedge clk); n++; end
        if (sb_q.size() != 0) begin
            check("rsp_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, n, lat, rsp_before;
        logic [7:0] rd;

        vecs[0] = '{1'b0, 8'h03, 8'h04, 8'h33, 8'h33};
        vecs[1] = '{1'b1, 8'h00, 8'h00, 8'h00, 8'h33};
        vecs[2] = '{1'b0, 8'hA5, 8'h5A, 8'hC3, 8'hC3};
        vecs[3] = '{1'b0, 8'hFF, 8'h00, 8'h00, 8'h00};
        vecs[4] = '{1'b0, 8'h00, 8'hFF, 8'hFF, 8'hFF};
        vecs[5] = '{1'b1, 8'hFF, 8'hFF, 8'h00, 8'hFF};
        vecs[6] = '{1'b0, 8'h80, 8'h01, 8'h81, 8'h81};

        rstn = 1'b0;
        cmd_valid = 1'b0; cmd_type = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        c3_cmd_valid = 1'b0; c3_cmd_type = 1'b0; c3_cmd_addr = '0; c3_cmd_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_sclk", 32'(sclk), 0);
        check("rst_iclk", 32'(iclk), 0);
        check("rst_serial_in", 32'(serial_in), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 0);
        check("rst_busy", 32'(busy), 0);
        rstn = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 1);

        for (int i = 0; i < 7; i++) begin
            send(vecs[i].typ, vecs[i].addr, vecs[i].wdata, vecs[i].so, vecs[i].rdata);
            wait_drain();
        end

        // cmd_valid held across a busy transfer: second command waits for IDLE.
        n = 0;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        cmd_valid = 1'b1; cmd_type = 1'b0; cmd_addr = 8'h11; cmd_wdata = 8'h22;
        a0 = cyc + 1;
        sb_q.push_back('{typ: 1'b0, addr: 8'h11, wdata: 8'h22, so: 8'h96, rdata: 8'h96, acc: a0});
        @(negedge clk);
        cmd_addr = 8'h33; cmd_wdata = 8'h44;
        n = 0;
        while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
        sb_q.push_back('{typ: 1'b0, addr: 8'h33, wdata: 8'h44, so: 8'h69, rdata: 8'h69, acc: cyc + 1});
        check("held_second_accept_edge", cyc + 1 - a0, 34);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_drain();

        // Reset during the sixth data slot aborts the transfer.
        send(1'b0, 8'h03, 8'h04, 8'h5A, 8'h5A);
        a0 = sb_q.size() > 0 ? sb_q[0].acc : cyc;
        n = 0;
        while (cyc != a0 + 28 && n < 100) begin @(negedge clk); n++; end
        check("abort_pre_sclk", 32'(sclk), 1);
        check("abort_pre_iclk", 32'(iclk), 1);
        check("abort_pre_serial_in", 32'(serial_in), 1);
        rsp_before = n_rsp;
        rstn = 1'b0;
        #1;
        sb_q.delete();
        check("abort_sclk", 32'(sclk), 0);
        check("abort_iclk", 32'(iclk), 0);
        check("abort_serial_in", 32'(serial_in), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_rsp_rdata", 32'(rsp_rdata), 0);
        repeat (3) @(negedge clk);
        check("abort_cmd_ready", 32'(cmd_ready), 1);
        rstn = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_no_rsp_valid", n_rsp - rsp_before, 0);
        send(1'b1, 8'hFF, 8'hFF, 8'h00, 8'h00);
        wait_drain();
        send(1'b0, 8'h03, 8'h04, 8'h5A, 8'h5A);
        wait_drain();

        // HALF_DIV=3 instance: timing, pattern and read-back.
        n = 0;
        while (!c3_cmd_ready && n < 100) begin @(negedge clk); n++; end
        c3_cmd_valid = 1'b1; c3_cmd_type = 1'b0; c3_cmd_addr = 8'hA5; c3_cmd_wdata = 8'h5A;
        a0 = cyc + 1;
        @(negedge clk);
        c3_cmd_valid = 1'b0;
        n = 0;
        while (!c3_rsp_valid && n < 300) begin @(negedge clk); n++; end
        lat = cyc - a0;
        rd  = c3_rsp_rdata;
        check("h3_rsp_busy", 32'(c3_busy), 1);
        @(negedge clk);
        check("h3_latency", lat, 97);
        check("h3_rdata", 32'(rd), 32'h3C);
        check("h3_bits", 32'(c3_bits), 32'hA55A);
        check("h3_sclk_pulses", c3_rises, 16);
        check("h3_run_length_errors", c3_bad, 0);
        check("h3_rsp_single_cycle", 32'(c3_rsp_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
